sim_dev_arbiter: RTL and testbench

Shares the single simulation-device port (the DPI-backed MMIO/device model) between NREQ requesters, e.g. ifetch, LSU and debug/DMA. A round-robin arbiter grants one requester and registers its request. The block then forwards the request downstream and routes the single response back to the owner. Only one transaction is outstanding at a time. A watchdog flags a response that never arrives.

---
 rtl/sim_dev_pkg.sv | 35 +++
 rtl/sim_dev_arbiter_rr.sv | 35 +++
 rtl/sim_dev_arbiter.sv | 158 +++++++++++++++
 tb/tb_sim_dev_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_dev_pkg.sv
// rtl/sim_dev_pkg.sv - shared widths, request struct, state enum and ring-index helper for the sim-device arbiter
package sim_dev_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 2;
  localparam int STRB_W = 4;

  localparam logic FUNC_RD = 1'b0;
  localparam logic FUNC_WR = 1'b1;

  typedef struct packed {
    logic              is_cached;
    logic              is_aligned;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] data;
    logic              func;
    logic [STRB_W-1:0] strb;
  } sim_dev_req_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } sim_dev_state_e;

  // (ptr + off) mod n, assuming ptr and off are both already below n
  function automatic int rr_index(input int ptr, input int off, input int n);
    int s;
    s = ptr + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/sim_dev_arbiter_rr.sv
// rtl/sim_dev_arbiter_rr.sv - round-robin picker: first valid requester at or after rr_ptr
module rr_arbiter
  import sim_dev_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  rr_ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  grant_idx_o,
  output logic            any_o
);

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  int                off;

  // Rotating a doubled copy puts rr_ptr at bit 0, so the lowest set bit is the pick.
  always_comb begin
    req_dbl     = {req_i, req_i};
    req_rot     = NREQ'(req_dbl >> rr_ptr_i);
    off         = 0;
    grant_o     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) off = k;
    end
    any_o       = |req_i;
    grant_idx_o = IDW'(rr_index(int'(rr_ptr_i), off, NREQ));
    for (int i = 0; i < NREQ; i++) begin
      grant_o[i] = any_o && (grant_idx_o == IDW'(i));
    end
  end

endmodule

// File: rtl/sim_dev_arbiter.sv
// rtl/sim_dev_arbiter.sv - shares the single simulation-device port among NREQ requesters, one transaction outstanding
module sim_dev_arbiter
  import sim_dev_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      in_req_valid,
  output logic [NREQ-1:0]      in_req_ready,
  input  logic [NREQ-1:0]      in_req_bits_is_cached,
  input  logic [NREQ-1:0]      in_req_bits_is_aligned,
  input  logic [NREQ*32-1:0]   in_req_bits_addr,
  input  logic [NREQ*2-1:0]    in_req_bits_len,
  input  logic [NREQ*32-1:0]   in_req_bits_data,
  input  logic [NREQ-1:0]      in_req_bits_func,
  input  logic [NREQ*4-1:0]    in_req_bits_strb,
  input  logic [NREQ-1:0]      in_resp_ready,
  output logic [NREQ-1:0]      in_resp_valid,
  output logic [31:0]          in_resp_bits_data,
  output logic                 out_req_valid,
  input  logic                 out_req_ready,
  output logic                 out_req_bits_is_cached,
  output logic                 out_req_bits_is_aligned,
  output logic [31:0]          out_req_bits_addr,
  output logic [1:0]           out_req_bits_len,
  output logic [31:0]          out_req_bits_data,
  output logic                 out_req_bits_func,
  output logic [3:0]           out_req_bits_strb,
  input  logic                 out_resp_valid,
  output logic                 out_resp_ready,
  input  logic [31:0]          out_resp_bits_data,
  output logic                 busy,
  output logic [IDW-1:0]       owner,
  output logic                 timeout_err
);

  localparam int             WDW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WDOG_LAST  = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [WDW-1:0] WDOG_MAX   = '1;
  localparam logic [IDW-1:0] LAST_IDX   = IDW'(NREQ - 1);

  sim_dev_state_e  state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  owner_q, owner_d;
  sim_dev_req_t    req_q, req_d;
  logic [WDW-1:0]  wdog_q, wdog_d;
  logic            timeout_err_q, timeout_err_d;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            grant_any;
  sim_dev_req_t    pick;
  logic [NREQ-1:0] owner_oh;
  logic            owner_resp_ready;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req_i       (in_req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_o       (grant_any)
  );

  always_comb begin
    pick     = '0;
    owner_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        pick.is_cached  = in_req_bits_is_cached[i];
        pick.is_aligned = in_req_bits_is_aligned[i];
        pick.addr       = in_req_bits_addr[ADDR_W*i +: ADDR_W];
        pick.len        = in_req_bits_len[LEN_W*i +: LEN_W];
        pick.data       = in_req_bits_data[DATA_W*i +: DATA_W];
        pick.func       = in_req_bits_func[i];
        pick.strb       = in_req_bits_strb[STRB_W*i +: STRB_W];
      end
      owner_oh[i] = (owner_q == IDW'(i));
    end
    owner_resp_ready = |(in_resp_ready & owner_oh);
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    owner_d        = owner_q;
    req_d          = req_q;
    wdog_d         = wdog_q;
    timeout_err_d  = timeout_err_q;
    in_req_ready   = '0;
    in_resp_valid  = '0;
    out_resp_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_req_ready   = grant;
        // Always drain here so a response orphaned by a mid-transaction reset cannot wedge the device.
        out_resp_ready = 1'b1;
        if (grant_any) begin
          req_d   = pick;
          owner_d = grant_idx;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (out_req_ready) begin
          state_d = S_RESP;
          wdog_d  = '0;
        end
      end
      S_RESP: begin
        in_resp_valid  = out_resp_valid ? owner_oh : '0;
        out_resp_ready = owner_resp_ready;
        if (wdog_q != WDOG_MAX) wdog_d = wdog_q + 1'b1;
        if (out_resp_valid && owner_resp_ready) begin
          state_d  = S_IDLE;
          rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
        end else if ((TIMEOUT != 0) && (wdog_q == WDOG_LAST)) begin
          timeout_err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      req_q         <= '0;
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      req_q         <= req_d;
      wdog_q        <= wdog_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign out_req_valid           = (state_q == S_REQ);
  assign out_req_bits_is_cached  = req_q.is_cached;
  assign out_req_bits_is_aligned = req_q.is_aligned;
  assign out_req_bits_addr       = req_q.addr;
  assign out_req_bits_len        = req_q.len;
  assign out_req_bits_data       = req_q.data;
  assign out_req_bits_func       = req_q.func;
  assign out_req_bits_strb       = req_q.strb;
  assign in_resp_bits_data       = out_resp_bits_data;
  assign busy                    = (state_q != S_IDLE);
  assign owner                   = owner_q;
  assign timeout_err             = timeout_err_q;

endmodule

// File: tb/tb_sim_dev_arbiter.sv
// tb/tb_sim_dev_arbiter.sv - directed self-checking bench for sim_dev_arbiter (NREQ=2, TIMEOUT=8)
module tb_sim_dev_arbiter;
  import sim_dev_pkg::*;

  logic        clock;
  logic        reset;
  logic [1:0]  in_req_valid;
  logic [1:0]  in_req_ready;
  logic [1:0]  in_req_bits_is_cached;
  logic [1:0]  in_req_bits_is_aligned;
  logic [63:0] in_req_bits_addr;
  logic [3:0]  in_req_bits_len;
  logic [63:0] in_req_bits_data;
  logic [1:0]  in_req_bits_func;
  logic [7:0]  in_req_bits_strb;
  logic [1:0]  in_resp_ready;
  logic [1:0]  in_resp_valid;
  logic [31:0] in_resp_bits_data;
  logic        out_req_valid;
  logic        out_req_ready;
  logic        out_req_bits_is_cached;
  logic        out_req_bits_is_aligned;
  logic [31:0] out_req_bits_addr;
  logic [1:0]  out_req_bits_len;
  logic [31:0] out_req_bits_data;
  logic        out_req_bits_func;
  logic [3:0]  out_req_bits_strb;
  logic        out_resp_valid;
  logic        out_resp_ready;
  logic [31:0] out_resp_bits_data;
  logic        busy;
  logic        owner;
  logic        timeout_err;

  int compared   = 0;
  int mismatched = 0;

  sim_dev_arbiter #(.NREQ(2), .TIMEOUT(8)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .in_req_valid            (in_req_valid),
    .in_req_ready            (in_req_ready),
    .in_req_bits_is_cached   (in_req_bits_is_cached),
    .in_req_bits_is_aligned  (in_req_bits_is_aligned),
    .in_req_bits_addr        (in_req_bits_addr),
    .in_req_bits_len         (in_req_bits_len),
    .in_req_bits_data        (in_req_bits_data),
    .in_req_bits_func        (in_req_bits_func),
    .in_req_bits_strb        (in_req_bits_strb),
    .in_resp_ready           (in_resp_ready),
    .in_resp_valid           (in_resp_valid),
    .in_resp_bits_data       (in_resp_bits_data),
    .out_req_valid           (out_req_valid),
    .out_req_ready           (out_req_ready),
    .out_req_bits_is_cached  (out_req_bits_is_cached),
    .out_req_bits_is_aligned (out_req_bits_is_aligned),
    .out_req_bits_addr       (out_req_bits_addr),
    .out_req_bits_len        (out_req_bits_len),
    .out_req_bits_data       (out_req_bits_data),
    .out_req_bits_func       (out_req_bits_func),
    .out_req_bits_strb       (out_req_bits_strb),
    .out_resp_valid          (out_resp_valid),
    .out_resp_ready          (out_resp_ready),
    .out_resp_bits_data      (out_resp_bits_data),
    .busy                    (busy),
    .owner                   (owner),
    .timeout_err             (timeout_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] e;
    reset = 1'b0;
    in_req_valid = '0; in_req_bits_is_cached = '0; in_req_bits_is_aligned = '0;
    in_req_bits_addr = '0; in_req_bits_len = '0; in_req_bits_data = '0;
    in_req_bits_func = '0; in_req_bits_strb = '0; in_resp_ready = '0;
    out_req_ready = 1'b0; out_resp_valid = 1'b0; out_resp_bits_data = '0;

    step(); step(); settle();
    chk("rst_out_req_valid", out_req_valid, 0);
    chk("rst_in_resp_valid", in_resp_valid, 0);
    chk("rst_in_req_ready", in_req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_req_addr", out_req_bits_addr, 0);

    // single read from req0
    reset = 1'b1;
    step();
    in_req_valid = 2'b01;
    in_req_bits_addr[31:0] = 32'h1fe0_0000;
    in_req_bits_func[0] = FUNC_RD;
    in_req_bits_len[1:0] = 2'd2;
    in_req_bits_strb[3:0] = 4'hf;
    in_req_bits_is_aligned[0] = 1'b1;
    settle();
    chk("rd_grant", in_req_ready, 2'b01);
    step();
    in_req_valid = '0; out_req_ready = 1'b1; settle();
    chk("rd_out_valid", out_req_valid, 1);
    chk("rd_addr", out_req_bits_addr, 32'h1fe0_0000);
    chk("rd_func", out_req_bits_func, 0);
    chk("rd_len", out_req_bits_len, 2);
    chk("rd_strb", out_req_bits_strb, 4'hf);
    chk("rd_aligned", out_req_bits_is_aligned, 1);
    chk("rd_cached", out_req_bits_is_cached, 0);
    chk("rd_busy", busy, 1);
    chk("rd_ready_low", in_req_ready, 0);
    step();
    out_req_ready = 1'b0; out_resp_valid = 1'b1; out_resp_bits_data = 32'hdead_beef;
    in_resp_ready = 2'b11; settle();
    chk("rd_resp_valid", in_resp_valid, 2'b01);
    chk("rd_resp_data", in_resp_bits_data, 32'hdead_beef);
    chk("rd_out_req_low", out_req_valid, 0);
    step();
    out_resp_valid = 1'b0; settle();
    chk("rd_idle", busy, 0);

    // write from req1 with downstream backpressure, then upstream response backpressure
    in_req_valid = 2'b10;
    in_req_bits_addr[63:32] = 32'h1000_0040;
    in_req_bits_data[63:32] = 32'h1234_5678;
    in_req_bits_len[3:2] = 2'd1;
    in_req_bits_func[1] = FUNC_WR;
    in_req_bits_strb[7:4] = 4'b0011;
    in_req_bits_is_cached[1] = 1'b0;
    in_req_bits_is_aligned[1] = 1'b1;
    settle();
    chk("wr_grant", in_req_ready, 2'b10);
    step();
    in_req_valid = '0;
    in_req_bits_addr = '1; in_req_bits_data = '1; in_req_bits_strb = '1; in_req_bits_len = '1;
    settle();
    for (int n = 0; n < 5; n++) begin
      chk("bp_out_valid", out_req_valid, 1);
      chk("bp_addr", out_req_bits_addr, 32'h1000_0040);
      chk("bp_data", out_req_bits_data, 32'h1234_5678);
      chk("bp_strb", out_req_bits_strb, 4'b0011);
      chk("bp_len", out_req_bits_len, 1);
      chk("bp_func", out_req_bits_func, 1);
      step(); settle();
    end
    out_req_ready = 1'b1; settle();
    chk("wr_owner", owner, 1);
    step();
    out_req_ready = 1'b0; out_resp_valid = 1'b1; out_resp_bits_data = 32'hcafe_f00d;
    in_resp_ready = 2'b01; settle();
    for (int n = 0; n < 3; n++) begin
      chk("rbp_out_resp_ready", out_resp_ready, 0);
      chk("rbp_busy", busy, 1);
      chk("rbp_resp_valid", in_resp_valid, 2'b10);
      step(); settle();
    end
    in_resp_ready = 2'b11; settle();
    chk("wr_out_resp_ready", out_resp_ready, 1);
    chk("wr_resp_valid", in_resp_valid, 2'b10);
    chk("wr_resp_data", in_resp_bits_data, 32'hcafe_f00d);
    step();
    out_resp_valid = 1'b0; settle();
    chk("wr_idle", busy, 0);

    // contention: both requesters held valid, pointer starts at 0
    in_req_valid = 2'b11; out_req_ready = 1'b1; out_resp_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e = (k % 2 == 0) ? 2'b01 : 2'b10;
      out_resp_bits_data = 32'h100 + 32'(k);
      settle();
      chk("ct_grant", in_req_ready, e);
      chk("ct_onehot", $countones(in_req_ready), 1);
      step(); settle();
      chk("ct_owner", owner, k % 2);
      chk("ct_ready_low", in_req_ready, 0);
      step(); settle();
      chk("ct_resp", in_resp_valid, e);
      step();
    end
    in_req_valid = '0; out_resp_valid = 1'b0; out_req_ready = 1'b0;

    // watchdog: no device response
    in_req_valid = 2'b01; settle();
    chk("wd_grant", in_req_ready, 2'b01);
    step();
    in_req_valid = '0; out_req_ready = 1'b1;
    step();
    out_req_ready = 1'b0;
    for (int n = 0; n < 8; n++) begin
      settle();
      chk("wd_not_yet", timeout_err, 0);
      step();
    end
    settle();
    chk("wd_set", timeout_err, 1);
    chk("wd_busy", busy, 1);
    repeat (3) step();
    settle();
    chk("wd_sticky", timeout_err, 1);
    out_resp_valid = 1'b1; out_resp_bits_data = 32'h55aa_55aa; settle();
    chk("wd_late_resp", in_resp_valid, 2'b01);
    chk("wd_late_data", in_resp_bits_data, 32'h55aa_55aa);
    step();
    out_resp_valid = 1'b0; settle();
    chk("wd_done", busy, 0);
    chk("wd_sticky_after", timeout_err, 1);

    // reset while in S_RESP, stray response afterwards
    in_req_valid = 2'b10; settle();
    chk("rs_grant", in_req_ready, 2'b10);
    step();
    in_req_valid = '0; out_req_ready = 1'b1;
    step();
    out_req_ready = 1'b0; settle();
    chk("rs_in_resp", busy, 1);
    out_resp_valid = 1'b1; out_resp_bits_data = 32'h77; in_resp_ready = 2'b11;
    #1 reset = 1'b0;
    #1;
    chk("rs_busy", busy, 0);
    chk("rs_out_req_valid", out_req_valid, 0);
    chk("rs_in_resp_valid", in_resp_valid, 0);
    chk("rs_timeout_err", timeout_err, 0);
    chk("rs_owner", owner, 0);
    step();
    reset = 1'b1; settle();
    chk("rs_drain_ready", out_resp_ready, 1);
    chk("rs_drain_no_valid", in_resp_valid, 0);
    chk("rs_drain_idle", busy, 0);
    step();
    out_resp_valid = 1'b0; in_req_valid = 2'b11; settle();
    chk("rs_ptr0_grant", in_req_ready, 2'b01);
    step();
    in_req_valid = '0; out_req_ready = 1'b1; settle();
    chk("rs_next_owner", owner, 0);
    chk("rs_next_out_valid", out_req_valid, 1);
    step();
    out_req_ready = 1'b0; out_resp_valid = 1'b1; out_resp_bits_data = 32'h99; settle();
    chk("rs_next_resp", in_resp_valid, 2'b01);
    chk("rs_next_data", in_resp_bits_data, 32'h99);
    step();
    out_resp_valid = 1'b0; settle();
    chk("rs_next_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
